arctan_arbiter: RTL

ARCTAN_ARBITER -- requirements
Module: arctan_arbiter

---
 rtl/arctan_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/arctan_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : arctan_arbiter
// Description : Round-robin arbiter sharing one fixed-latency arctan unit
//               among N_REQ requesters, with tag-based result routing.
// Revision    : 1.0 - initial release
// ============================================================================
module arctan_arbiter #(
  parameter int N_REQ = 4,
  parameter int LAT   = 36,
  parameter int DW    = 18
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DW-1:0]        req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic [DW-1:0]              atan_in,
  input  logic [DW-1:0]              atan_out,
  output logic [N_REQ-1:0]           rsp_valid,
  output logic [DW-1:0]              rsp_data,
  output logic [$clog2(LAT+2)-1:0]   inflight
);

  localparam int             PW      = $clog2(N_REQ);
  localparam int             IW      = $clog2(LAT+2);
  localparam logic [PW-1:0]  LAST_ID = PW'(N_REQ - 1);
  localparam logic [PW:0]    NUM     = (PW+1)'(N_REQ);

  logic [PW-1:0]   r_ptr;
  logic [LAT:0]    r_tag_v;
  logic [PW-1:0]   r_tag_id [0:LAT];

  logic            w_hs;
  logic            w_retire;
  logic [PW-1:0]   w_win_id;
  logic [DW-1:0]   w_win_data;
  logic [PW:0]     w_sum;
  logic [PW:0]     w_cand;
  logic [DW-1:0]   w_data [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign w_data[gi] = req_data[gi*DW +: DW];
    end
  endgenerate

  // Search upward from r_ptr with wrap; first valid requester wins.
  always_comb begin
    req_ready = '0;
    w_hs      = 1'b0;
    w_win_id  = '0;
    w_sum     = '0;
    w_cand    = '0;
    if (en && !rst) begin
      for (int k = 0; k < N_REQ; k++) begin
        w_sum  = {1'b0, r_ptr} + (PW+1)'(k);
        w_cand = (w_sum >= NUM) ? (w_sum - NUM) : w_sum;
        if (!w_hs && req_valid[PW'(w_cand)]) begin
          w_hs                   = 1'b1;
          w_win_id               = PW'(w_cand);
          req_ready[PW'(w_cand)] = 1'b1;
        end
      end
    end
  end

  assign w_win_data = w_data[w_win_id];
  assign w_retire   = r_tag_v[LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= '0;
      r_tag_v   <= '0;
      atan_in   <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      inflight  <= '0;
      for (int k = 0; k <= LAT; k++) begin
        r_tag_id[k] <= '0;
      end
    end else begin
      if (w_hs) begin
        r_ptr <= (w_win_id == LAST_ID) ? '0 : (w_win_id + PW'(1));
      end

      atan_in <= w_hs ? w_win_data : '0;

      // Tag position k is valid in cycle t+1+k, so the last stage lines up
      // with the shared unit's output for the operand issued at cycle t.
      r_tag_v     <= {r_tag_v[LAT-1:0], w_hs};
      r_tag_id[0] <= w_win_id;
      for (int k = 1; k <= LAT; k++) begin
        r_tag_id[k] <= r_tag_id[k-1];
      end

      if (w_retire) begin
        rsp_valid <= {{(N_REQ-1){1'b0}}, 1'b1} << r_tag_id[LAT];
        rsp_data  <= atan_out;
      end else begin
        rsp_valid <= '0;
      end

      case ({w_hs, w_retire})
        2'b10:   inflight <= inflight + IW'(1);
        2'b01:   inflight <= inflight - IW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

endmodule
`default_nettype wire
